// File: rtl/irq_fifo_mq.sv
// Multi-queue interrupt FIFO: NUM_QUEUES circular queues in one shared RAM, popped over the config bus.
// Latency: push lands in one cycle and irq_sig follows on the next; config responses are registered (T+1).
// Backpressure: one push per cycle, lowest-index non-full queue wins; losers and full-queue pushes are dropped.
module irq_fifo_mq #(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_QUEUES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [13:0]           config_addr,
    input  logic                  config_en,
    input  logic                  config_wr,
    input  logic [31:0]           config_wdata,
    input  logic                  sel,
    input  logic [NUM_QUEUES-1:0] push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [NUM_QUEUES-1:0] push_accept,
    output logic [31:0]           config_slv_rdata,
    output logic                  config_slv_error,
    output logic [NUM_QUEUES-1:0] irq_sig
);
    localparam int QW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int AW = QW + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [2**AW];
    logic [DEPTH_LOG2:0]   wptr [NUM_QUEUES];
    logic [DEPTH_LOG2:0]   rptr [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] empty, full, overflow, mask, ovf_set, ovf_clr, pop_vec;
    logic                  push_hit;
    logic [QW-1:0]         push_q;
    logic [DEPTH_LOG2-1:0] push_w;
    logic [DEPTH_LOG2:0]   sel_cnt;
    logic [DEPTH_LOG2-1:0] sel_r;
    logic                  sel_empty, sel_full;
    logic                  req, in_range, pop_en, mask_we, err_nxt;
    logic [10:0]           addr;
    logic [QW-1:0]         qi;
    logic [31:0]           rdata_nxt, status;
    logic                  unused_bits;

    assign unused_bits = ^{config_addr[13:11], config_wdata[31:NUM_QUEUES]};

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            empty[q] = (wptr[q] == rptr[q]);
            full[q]  = ((wptr[q] - rptr[q]) == FULL_CNT);
        end
    end

    assign irq_sig = ~empty & ~mask;

    // Full is judged on start-of-cycle pointers, so a same-cycle pop never frees a slot for a push.
    always_comb begin
        push_accept = '0;
        push_hit    = 1'b0;
        push_q      = '0;
        push_w      = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!push_hit && push_valid[q] && !full[q]) begin
                push_accept[q] = 1'b1;
                push_hit       = 1'b1;
                push_q         = QW'(q);
                push_w         = wptr[q][DEPTH_LOG2-1:0];
            end
        end
        ovf_set = push_valid & full;
    end

    always_comb begin
        addr      = config_addr[10:0];
        req       = sel & config_en;
        qi        = addr[QW-1:0];
        in_range  = addr[7:0] < 8'(NUM_QUEUES);
        sel_cnt   = '0;
        sel_r     = '0;
        sel_empty = 1'b1;
        sel_full  = 1'b0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (addr[7:0] == 8'(q)) begin
                sel_cnt   = wptr[q] - rptr[q];
                sel_r     = rptr[q][DEPTH_LOG2-1:0];
                sel_empty = empty[q];
                sel_full  = full[q];
            end
        end
        status                 = '0;
        status[DEPTH_LOG2:0]   = sel_cnt;
        status[30]             = sel_empty;
        status[31]             = sel_full;

        pop_en    = 1'b0;
        ovf_clr   = '0;
        mask_we   = 1'b0;
        rdata_nxt = config_slv_rdata;
        err_nxt   = 1'b0;
        if (req) begin
            rdata_nxt = '0;
            err_nxt   = 1'b1;
            if (addr[10:8] == 3'd0 && in_range && !config_wr) begin
                if (!sel_empty) begin
                    rdata_nxt = 32'(mem[{qi, sel_r}]);
                    err_nxt   = 1'b0;
                    pop_en    = 1'b1;
                end
            end else if (addr[10:8] == 3'd1 && in_range && !config_wr) begin
                rdata_nxt = status;
                err_nxt   = 1'b0;
            end else if (addr == 11'h200) begin
                err_nxt = 1'b0;
                if (config_wr) ovf_clr   = config_wdata[NUM_QUEUES-1:0];
                else           rdata_nxt = 32'(overflow);
            end else if (addr == 11'h201) begin
                err_nxt = 1'b0;
                if (config_wr) mask_we   = 1'b1;
                else           rdata_nxt = 32'(mask);
            end
        end
        pop_vec = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (pop_en && addr[7:0] == 8'(q)) pop_vec[q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                wptr[q] <= '0;
                rptr[q] <= '0;
            end
            overflow         <= '0;
            mask             <= '0;
            config_slv_rdata <= '0;
            config_slv_error <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (push_accept[q]) wptr[q] <= wptr[q] + PTR_ONE;
                if (pop_vec[q])     rptr[q] <= rptr[q] + PTR_ONE;
            end
            // Set after clear: a new overflow beats a same-cycle W1C.
            overflow         <= (overflow & ~ovf_clr) | ovf_set;
            if (mask_we) mask <= config_wdata[NUM_QUEUES-1:0];
            config_slv_rdata <= rdata_nxt;
            config_slv_error <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_hit) mem[{push_q, push_w}] <= push_data;
    end
endmodule

// File: doc/irq_fifo_mq.md
Name: irq_fifo_mq

Overview:
- Parametrised multi-queue interrupt FIFO for the network interface; successor to the fixed two-queue, 14-bit IRQ/data FIFO.
- Holds NUM_QUEUES independent circular queues in one shared dual-port RAM, with one write port for pushes and one read port for pops.
- Raises a maskable per-queue interrupt while its queue is non-empty.
- The processor pops entries, reads fill levels, and manages sticky overflow flags and the mask over the config slave bus.

Parameters:
- DATA_WIDTH, 14, entry width; legal range 1..32.
- DEPTH_LOG2, 4, log2 of entries per queue; every slot is usable.
- NUM_QUEUES, 2, number of queues; legal range 1..16. Queue 0 is the IRQ queue, queue 1 is the data queue.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- config_addr  in  14  config address; only [10:0] is decoded.
- config_en  in  1  request strobe.
- config_wr  in  1  1 = write, 0 = read.
- config_wdata  in  32  write data.
- sel  in  1  slave select; a request is valid when sel & config_en.
- push_valid  in  NUM_QUEUES  per-queue push request.
- push_data  in  DATA_WIDTH  push payload, shared by all queues.
- push_accept  out  NUM_QUEUES  combinational; the push was written this cycle.
- config_slv_rdata  out  32  registered read response.
- config_slv_error  out  1  registered error response.
- irq_sig  out  NUM_QUEUES  per-queue interrupt: not_empty & ~mask.

Behaviour:
- Pointers: each queue has a (DEPTH_LOG2+1)-bit write pointer and read pointer.
  - count = w - r, modulo 2^(DEPTH_LOG2+1).
  - empty when count == 0; full when count == 2^DEPTH_LOG2.
  - RAM address = {queue index, pointer[DEPTH_LOG2-1:0]}.
  - Pointers wrap naturally; there is no special wrap case.
- Push arbitration:
  - One RAM write per cycle.
  - The lowest-index queue with push_valid & ~full wins and gets push_accept = 1.
  - All other requesting queues get push_accept = 0, and their data is dropped.
  - A push_valid to a full queue sets overflow[i] (sticky), whether or not it would have won arbitration.
- Config decode (request cycle T, response valid in T+1; rdata/error hold until the next request):
  - 0x000+i, read = pop queue i.
    - If non-empty: rdata = zero-extended RAM[{i, r}], r increments, error = 0.
    - If empty: rdata = 0, no pointer change, error = 1.
  - 0x100+i, read = status of queue i: [DEPTH_LOG2:0] = count, bit 30 = empty, bit 31 = full, all other bits 0.
  - 0x200: read returns overflow[NUM_QUEUES-1:0]; write clears each bit where wdata has a 1 (W1C).
  - 0x201: read returns mask; write loads mask from wdata[NUM_QUEUES-1:0].
  - Any other address, a write to a pop or status address, or i >= NUM_QUEUES: error = 1, rdata = 0, no state change.
  - No request in T: in T+1 rdata holds, error = 0.
- Simultaneous events:
  - Full and empty are evaluated from registered pointers at the start of the cycle.
  - Push and pop on the same queue in one cycle both take effect.
  - Push to a queue that is full at cycle start is rejected, even if a pop to that queue occurs in the same cycle.
  - Pop from a queue that is empty at cycle start returns an error, even if a push to that queue occurs in the same cycle.
  - A W1C clear and a new overflow on the same bit in the same cycle: the set wins.
- Reset (asserted asynchronously, at any time including mid-transaction):
  - All pointers = 0, so all queues are empty.
  - overflow = 0, mask = 0 (all interrupts enabled).
  - config_slv_rdata = 0, config_slv_error = 0.
  - irq_sig = 0.
  - RAM contents are not reset.
- Release of reset is synchronised by the system; the first push may occur on the first clk edge after release.
- irq_sig is combinational from the pointer and mask registers; it asserts the cycle after the first accepted push.

Test Plan (defaults):
1. Reset, then push 0x0A5 to queue 0 -> push_accept = 01, irq_sig = 01 next cycle; read 0x000 -> next cycle rdata = 0x000000A5, error = 0, irq_sig = 00.
2. Push 16 entries (values 0..15) to queue 1, then a 17th -> push_accept low on the 17th, overflow = 0b10; read 0x101 -> rdata = 0x80000010; pop 16 times -> values 0..15 in order; a further pop -> error = 1, rdata = 0.
3. push_valid = 11 in the same cycle with push_data = 0x123 -> only queue 0 accepts; queue 1 count stays 0 and overflow stays 00.
4. With queue 0 full, issue a pop on 0x000 and a push in the same cycle -> pop returns the oldest entry, push is rejected, overflow[0] = 1, count = 15. Then write 0x200 with 0x1 -> overflow = 0.
5. Write 0x201 = 0x2, then push to queue 1 -> irq_sig stays 00 and count = 1; write 0x201 = 0 -> irq_sig = 10.
6. Assert reset_n = 0 mid-sequence with 5 entries queued -> status reads count 0; irq_sig, overflow, mask and rdata all 0. Also: a write to 0x000, or a read of 0x102 -> error = 1.
